rr_arbiter: RTL

Round-robin arbiter that shares one datapath resource among NUM_REQ requesters with a one-hot grant. Grant ownership is held until the owner signals completion, drops its request, or exceeds a hold limit while others wait. The block is a registered Moore controller that sits between the requesting engines and the shared resource's enable and select inputs. Its rotating one-hot priority pointer guarantees starvation-free access.

---
 rtl/arb_pkg.sv | 20 ++
 rtl/rr_pick.sv | 51 +++++
 rtl/rr_arbiter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared definitions for the round-robin arbiter:
//   arb_state_t  - controller states (IDLE, GRANT, RELEASE)
//   PTR_RESET    - reset value of the one-hot priority pointer; the top level
//                  slices off the low NUM_REQ bits, so requester 0 starts with
//                  highest priority.
// -----------------------------------------------------------------------------
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    localparam int unsigned PTR_MAX_W = 64;
    localparam logic [PTR_MAX_W-1:0] PTR_RESET = 64'd1;

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin pick: selects the first asserted request at or
// above the one-hot pointer, wrapping from the MSB back to bit 0.
//
// Ports:
//   req   in   NUM_REQ  request vector
//   ptr   in   NUM_REQ  one-hot priority pointer
//   pick  out  NUM_REQ  one-hot winner (all zero when no request)
//   idx   out  IDX_W    binary index of the winner (0 when no request)
//   any   out  1        at least one request asserted
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] ptr,
    output logic [NUM_REQ-1:0] pick,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    localparam logic [NUM_REQ-1:0]   ONE_N  = NUM_REQ'(1);
    localparam logic [2*NUM_REQ-1:0] ONE_2N = (2*NUM_REQ)'(1);

    logic [NUM_REQ-1:0]   mask;
    logic [2*NUM_REQ-1:0] dreq;
    logic [2*NUM_REQ-1:0] dgnt;

    // The low half holds only requests at or above ptr; the high half holds
    // every request and so supplies the wrap-around candidate. Isolating the
    // lowest set bit of the doubled vector gives the round-robin winner.
    assign mask = ~(ptr - ONE_N);
    assign dreq = {req, req & mask};
    assign dgnt = dreq & ~(dreq - ONE_2N);
    assign pick = dgnt[NUM_REQ-1:0] | dgnt[2*NUM_REQ-1:NUM_REQ];
    assign any  = |req;

    always_comb begin
        // NOTE: give every combinational output a default before any
        // conditional assignment so no path leaves it unassigned (no latch).
        idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter with a registered one-hot grant. The owner keeps the
// grant until it pulses done, drops its request, or holds for MAX_HOLD cycles
// while another requester waits. Every release is followed by a single
// grant-free RELEASE cycle before the next arbitration.
//
// Ports:
//   clk        in   1        clock, all logic on posedge
//   rst        in   1        synchronous active-high reset
//   req        in   NUM_REQ  level request per requester
//   done       in   NUM_REQ  completion pulse, only the owner's bit counts
//   gnt        out  NUM_REQ  registered one-hot grant
//   gnt_valid  out  1        registered OR of gnt
//   gnt_id     out  IDX_W    registered binary owner index (0 when idle)
//   timeout    out  1        pulse in the RELEASE cycle caused by the hold limit
// -----------------------------------------------------------------------------
module rr_arbiter
    import arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int MAX_HOLD = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         done,
    output logic [NUM_REQ-1:0]         gnt,
    output logic                       gnt_valid,
    output logic [$clog2(NUM_REQ)-1:0] gnt_id,
    output logic                       timeout
);

    localparam int IDX_W    = $clog2(NUM_REQ);
    localparam int HOLD_W   = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam int HOLD_SAT = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_SAT);
    localparam logic [NUM_REQ-1:0] PTR_INIT  = PTR_RESET[NUM_REQ-1:0];

    arb_state_t state_q, state_d;
    logic [NUM_REQ-1:0] ptr_q, ptr_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0]   gnt_id_q, gnt_id_d;
    logic               gnt_valid_q, gnt_valid_d;
    logic               timeout_q, timeout_d;

    logic [NUM_REQ-1:0] pick;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;

    logic owner_done;
    logic owner_req;
    logic others_req;
    logic hold_hit;
    logic release_grant;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req  (req),
        .ptr  (ptr_q),
        .pick (pick),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    // Only the current owner's done/req bits matter; gnt_id_q is 0 outside
    // GRANT, but these terms are consumed only in GRANT.
    assign owner_done    = done[gnt_id_q];
    assign owner_req     = req[gnt_id_q];
    assign others_req    = |(req & ~gnt_q);
    assign hold_hit      = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST) && others_req;
    assign release_grant = owner_done || !owner_req || hold_hit;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= PTR_INIT;
            hold_cnt_q  <= '0;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, RELEASE: state_d = pick_any ? GRANT : IDLE;
            GRANT:         state_d = release_grant ? RELEASE : GRANT;
            default:       state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs, pointer and hold counter.
    always_comb begin
        gnt_d      = gnt_q;
        gnt_id_d   = gnt_id_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        timeout_d  = 1'b0;
        unique case (state_q)
            IDLE, RELEASE: begin
                if (pick_any) begin
                    gnt_d      = pick;
                    gnt_id_d   = pick_idx;
                    hold_cnt_d = '0;
                end else begin
                    gnt_d    = '0;
                    gnt_id_d = '0;
                end
            end
            GRANT: begin
                if (release_grant) begin
                    gnt_d      = '0;
                    gnt_id_d   = '0;
                    hold_cnt_d = '0;
                    // Next arbitration starts just past the departing owner.
                    ptr_d      = {gnt_q[NUM_REQ-2:0], gnt_q[NUM_REQ-1]};
                    // Flag only releases the hold limit caused on its own.
                    timeout_d  = hold_hit && owner_req && !owner_done;
                end else if ((MAX_HOLD != 0) && (hold_cnt_q != HOLD_LAST)) begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            default: begin
                gnt_d    = '0;
                gnt_id_d = '0;
            end
        endcase
        gnt_valid_d = |gnt_d;
    end

    assign gnt       = gnt_q;
    assign gnt_valid = gnt_valid_q;
    assign gnt_id    = gnt_id_q;
    assign timeout   = timeout_q;

endmodule
